// File: rtl/cycle_sequencer_if.sv
// CPU-side bus bundle for the cycle sequencer: strobes and decode hits in,
// grant / termination / burst / error indications out.
interface cycle_sequencer_if;
    logic       AS20;
    logic       DS20;
    logic       RW20;
    logic [3:0] REQ;
    logic [1:0] A;
    logic       CBREQ;
    logic [3:0] GNT;
    logic       DOE;
    logic       STERM;
    logic       CBACK;
    logic [1:0] RAMA;
    logic       INTCYCLE;
    logic       BERR;

    // CPU / decoder side
    modport master (
        output AS20, DS20, RW20, REQ, A, CBREQ,
        input  GNT, DOE, STERM, CBACK, RAMA, INTCYCLE, BERR
    );

    // Sequencer side
    modport slave (
        input  AS20, DS20, RW20, REQ, A, CBREQ,
        output GNT, DOE, STERM, CBACK, RAMA, INTCYCLE, BERR
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Bus cycle sequencer: grants one internal responder per CPU cycle, inserts
// wait states, terminates with STERM, runs 4-beat RAM cache bursts and
// signals a bus error when an IO responder never gets its data strobe.
module cycle_sequencer #(
    parameter int         RAM_WS  = 0,
    parameter int         IO_WS   = 2,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                CLKCPU,
    input  logic                RESET,
    cycle_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WAIT, S_ACK, S_BURST, S_TERM, S_PASS, S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [7:0] cnt_q, cnt_d;     // wait states left, or burst beats left
    logic [7:0] tmo_q, tmo_d;     // WAIT cycles spent in this access
    logic [1:0] rama_q, rama_d;
    logic       sterm_q, sterm_d;
    logic       cback_q, cback_d;
    logic       berr_q, berr_d;
    logic       armed_q, armed_d; // AS20 seen high since reset

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        rama_d  = rama_q;
        sterm_d = sterm_q;
        cback_d = cback_q;
        berr_d  = berr_q;
        armed_d = armed_q | bus.AS20;

        if (state_q != S_IDLE && bus.AS20) begin
            // CPU ended the cycle: abandon whatever was in progress
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = 8'd0;
            tmo_d   = 8'd0;
            rama_d  = bus.A;
            sterm_d = 1'b1;
            cback_d = 1'b1;
            berr_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rama_d = bus.A;
                    gnt_d  = 4'b0000;
                    if (armed_q && !bus.AS20)
                        state_d = S_DECODE;
                end
                S_DECODE: begin
                    rama_d  = bus.A;
                    tmo_d   = 8'd0;
                    state_d = S_WAIT;
                    if (bus.REQ[0]) begin
                        gnt_d = 4'b0001;
                        cnt_d = 8'(RAM_WS);
                    end else if (bus.REQ[1]) begin
                        gnt_d = 4'b0010;
                        cnt_d = 8'(IO_WS);
                    end else if (bus.REQ[2]) begin
                        gnt_d = 4'b0100;
                        cnt_d = 8'(IO_WS);
                    end else if (bus.REQ[3]) begin
                        gnt_d = 4'b1000;
                        cnt_d = 8'(IO_WS);
                    end else begin
                        gnt_d   = 4'b0000;
                        state_d = S_PASS;
                    end
                end
                S_WAIT: begin
                    rama_d = bus.A;
                    if (cnt_q == 8'd0) begin
                        state_d = S_ACK;
                        sterm_d = 1'b0;
                        // Burst is decided once, on entry to the first beat
                        if (gnt_q[0] && bus.RW20 && !bus.CBREQ)
                            cback_d = 1'b0;
                    end else begin
                        // IO responders only count while the data strobe is out
                        if (gnt_q[0] || !bus.DS20)
                            cnt_d = cnt_q - 8'd1;
                        tmo_d = tmo_q + 8'd1;
                        if ({1'b0, tmo_q} + 9'd1 == {1'b0, TIMEOUT}) begin
                            state_d = S_ERR;
                            berr_d  = 1'b0;
                        end
                    end
                end
                S_ACK: begin
                    if (!cback_q) begin
                        state_d = S_BURST;
                        cnt_d   = 8'd2;
                        rama_d  = rama_q + 2'd1;
                    end else begin
                        state_d = S_TERM;
                        sterm_d = 1'b1;
                    end
                end
                S_BURST: begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_TERM;
                        sterm_d = 1'b1;
                        cback_d = 1'b1;
                        rama_d  = bus.A;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        rama_d = rama_q + 2'd1;
                        // CBACK rises on the last beat
                        if (cnt_q == 8'd1)
                            cback_d = 1'b1;
                    end
                end
                S_TERM, S_PASS: begin
                    sterm_d = 1'b1;
                    cback_d = 1'b1;
                end
                S_ERR: begin
                    berr_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously by RESET
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            cnt_q   <= 8'd0;
            tmo_q   <= 8'd0;
            rama_q  <= 2'b00;
            sterm_q <= 1'b1;
            cback_q <= 1'b1;
            berr_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            rama_q  <= rama_d;
            sterm_q <= sterm_d;
            cback_q <= cback_d;
            berr_q  <= berr_d;
            armed_q <= armed_d;
        end
    end

    // Strobe-type outputs are gated off the moment AS20 goes high
    assign bus.GNT      = gnt_q;
    assign bus.RAMA     = rama_q;
    assign bus.STERM    = sterm_q | bus.AS20;
    assign bus.CBACK    = cback_q | bus.AS20;
    assign bus.BERR     = berr_q  | bus.AS20;
    assign bus.DOE      = (gnt_q != 4'b0000) & bus.RW20 & ~bus.AS20;
    assign bus.INTCYCLE = ~(gnt_q != 4'b0000);

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: reset, RAM read, RAM burst, IO wait
// states on read and write, timeout bus error, pass-through and reset abort.
module tb_cycle_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cycle_sequencer_if bus();

    cycle_sequencer dut (
        .CLKCPU (clk),
        .RESET  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic end_cycle();
        bus.AS20 = 1'b1;
        bus.DS20 = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.AS20 = 1'b1; bus.DS20 = 1'b1; bus.RW20 = 1'b1;
        bus.REQ = 4'b0001; bus.A = 2'b11; bus.CBREQ = 1'b1;
        #3;
        checks++; if (bus.GNT !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.GNT); end
        checks++; if ({bus.STERM, bus.CBACK, bus.BERR, bus.INTCYCLE} !== 4'b1111) begin failures++; $display("FAIL reset_strobes got=%b exp=1111", {bus.STERM, bus.CBACK, bus.BERR, bus.INTCYCLE}); end
        checks++; if (bus.DOE !== 1'b0) begin failures++; $display("FAIL reset_doe got=%b exp=0", bus.DOE); end
        checks++; if (bus.RAMA !== 2'b00) begin failures++; $display("FAIL reset_rama got=%b exp=00", bus.RAMA); end
        tick(); tick();
        // Release with AS20 already low: must not start a cycle until AS20 seen high
        bus.AS20 = 1'b0; bus.DS20 = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (bus.GNT !== 4'b0000 || bus.STERM !== 1'b1) begin failures++; $display("FAIL reset_no_start gnt=%b sterm=%b exp=0000/1", bus.GNT, bus.STERM); end
        end_cycle();
    endtask

    task automatic test_ram_read();
        bus.REQ = 4'b0001; bus.RW20 = 1'b1; bus.CBREQ = 1'b1; bus.A = 2'b01;
        bus.AS20 = 1'b0; bus.DS20 = 1'b0;
        tick();                                   // IDLE -> DECODE
        checks++; if (bus.STERM !== 1'b1) begin failures++; $display("FAIL ram_sterm_decode got=%b exp=1", bus.STERM); end
        tick();                                   // DECODE -> WAIT
        checks++; if (bus.GNT !== 4'b0001) begin failures++; $display("FAIL ram_gnt got=%b exp=0001", bus.GNT); end
        checks++; if (bus.INTCYCLE !== 1'b0 || bus.DOE !== 1'b1) begin failures++; $display("FAIL ram_int_doe got=%b%b exp=01", bus.INTCYCLE, bus.DOE); end
        checks++; if (bus.RAMA !== 2'b01 || bus.STERM !== 1'b1) begin failures++; $display("FAIL ram_wait rama=%b sterm=%b exp=01/1", bus.RAMA, bus.STERM); end
        tick();                                   // WAIT -> ACK
        checks++; if (bus.STERM !== 1'b0 || bus.CBACK !== 1'b1) begin failures++; $display("FAIL ram_ack sterm=%b cback=%b exp=0/1", bus.STERM, bus.CBACK); end
        tick();                                   // ACK -> TERM
        checks++; if (bus.STERM !== 1'b1 || bus.CBACK !== 1'b1) begin failures++; $display("FAIL ram_term sterm=%b cback=%b exp=1/1", bus.STERM, bus.CBACK); end
        bus.AS20 = 1'b1; bus.DS20 = 1'b1;
        tick();
        checks++; if (bus.GNT !== 4'b0000 || bus.INTCYCLE !== 1'b1) begin failures++; $display("FAIL ram_idle gnt=%b int=%b exp=0000/1", bus.GNT, bus.INTCYCLE); end
        tick();
    endtask

    // Runs a burst from A=2; stops after 'beats' beats when abort is set
    task automatic run_burst(input int beats, input bit abort);
        logic [1:0] exp_rama [4];
        logic       exp_cback[4];
        exp_rama  = '{2'd2, 2'd3, 2'd0, 2'd1};
        exp_cback = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus.REQ = 4'b0001; bus.RW20 = 1'b1; bus.CBREQ = 1'b0; bus.A = 2'b10;
        bus.AS20 = 1'b0; bus.DS20 = 1'b0;
        tick(); tick();
        for (int b = 0; b < beats; b++) begin
            tick();
            checks++; if (bus.STERM !== 1'b0 || bus.CBACK !== exp_cback[b] || bus.RAMA !== exp_rama[b]) begin
                failures++; $display("FAIL burst_beat%0d sterm=%b cback=%b rama=%0d exp=0/%b/%0d", b, bus.STERM, bus.CBACK, bus.RAMA, exp_cback[b], exp_rama[b]);
            end
        end
        if (!abort) begin
            tick();
            checks++; if (bus.STERM !== 1'b1 || bus.CBACK !== 1'b1) begin failures++; $display("FAIL burst_term sterm=%b cback=%b exp=1/1", bus.STERM, bus.CBACK); end
            end_cycle();
        end
    endtask

    task automatic test_io(input logic rw);
        logic exp_doe;
        exp_doe = rw;
        bus.REQ = 4'b0110; bus.RW20 = rw; bus.CBREQ = 1'b0; bus.A = 2'b00;
        bus.AS20 = 1'b0; bus.DS20 = 1'b0;
        tick(); tick();                           // now in WAIT, count 2
        checks++; if (bus.GNT !== 4'b0010) begin failures++; $display("FAIL io_gnt got=%b exp=0010", bus.GNT); end
        checks++; if (bus.DOE !== exp_doe) begin failures++; $display("FAIL io_doe rw=%b got=%b exp=%b", rw, bus.DOE, exp_doe); end
        bus.REQ = 4'b0001;                        // late decode change is ignored
        tick();
        checks++; if (bus.STERM !== 1'b1 || bus.GNT !== 4'b0010) begin failures++; $display("FAIL io_wait1 sterm=%b gnt=%b exp=1/0010", bus.STERM, bus.GNT); end
        tick();
        checks++; if (bus.STERM !== 1'b1) begin failures++; $display("FAIL io_wait2 sterm=%b exp=1", bus.STERM); end
        tick();
        checks++; if (bus.STERM !== 1'b0 || bus.CBACK !== 1'b1) begin failures++; $display("FAIL io_ack sterm=%b cback=%b exp=0/1", bus.STERM, bus.CBACK); end
        tick();
        checks++; if (bus.STERM !== 1'b1) begin failures++; $display("FAIL io_term sterm=%b exp=1", bus.STERM); end
        end_cycle();
    endtask

    task automatic test_timeout();
        bus.REQ = 4'b0100; bus.RW20 = 1'b1; bus.CBREQ = 1'b1; bus.A = 2'b00;
        bus.AS20 = 1'b0; bus.DS20 = 1'b1;
        tick(); tick();                           // DECODE -> WAIT
        repeat (254) tick();
        checks++; if (bus.BERR !== 1'b1 || bus.GNT !== 4'b0100) begin failures++; $display("FAIL tmo_before berr=%b gnt=%b exp=1/0100", bus.BERR, bus.GNT); end
        tick();                                   // 255th WAIT cycle
        checks++; if (bus.BERR !== 1'b0 || bus.STERM !== 1'b1) begin failures++; $display("FAIL tmo_berr berr=%b sterm=%b exp=0/1", bus.BERR, bus.STERM); end
        tick(); tick();
        checks++; if (bus.BERR !== 1'b0) begin failures++; $display("FAIL tmo_hold berr=%b exp=0", bus.BERR); end
        bus.AS20 = 1'b1;
        #1;
        checks++; if (bus.BERR !== 1'b1) begin failures++; $display("FAIL tmo_as_gate berr=%b exp=1", bus.BERR); end
        tick();
        checks++; if (bus.BERR !== 1'b1 || bus.GNT !== 4'b0000) begin failures++; $display("FAIL tmo_idle berr=%b gnt=%b exp=1/0000", bus.BERR, bus.GNT); end
        tick();
    endtask

    task automatic test_pass();
        bus.REQ = 4'b0000; bus.RW20 = 1'b1; bus.CBREQ = 1'b0; bus.A = 2'b00;
        bus.AS20 = 1'b0; bus.DS20 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (bus.INTCYCLE !== 1'b1 || bus.STERM !== 1'b1 || bus.DOE !== 1'b0 || bus.GNT !== 4'b0000) begin
                failures++; $display("FAIL pass_cyc%0d int=%b sterm=%b doe=%b gnt=%b exp=1/1/0/0000", i, bus.INTCYCLE, bus.STERM, bus.DOE, bus.GNT);
            end
        end
        end_cycle();
    endtask

    task automatic test_reset_burst();
        run_burst(2, 1'b1);                       // stopped on beat 2
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.GNT !== 4'b0000 || bus.RAMA !== 2'b00 || bus.DOE !== 1'b0) begin failures++; $display("FAIL rstb_regs gnt=%b rama=%b doe=%b exp=0000/00/0", bus.GNT, bus.RAMA, bus.DOE); end
        checks++; if ({bus.STERM, bus.CBACK, bus.BERR, bus.INTCYCLE} !== 4'b1111) begin failures++; $display("FAIL rstb_strobes got=%b exp=1111", {bus.STERM, bus.CBACK, bus.BERR, bus.INTCYCLE}); end
        tick();
        bus.AS20 = 1'b1; bus.DS20 = 1'b1;
        rst = 1'b1;
        tick(); tick();
        test_ram_read();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ram_read();
        run_burst(4, 1'b0);
        test_io(1'b1);
        test_io(1'b0);
        test_timeout();
        test_pass();
        test_reset_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
